// File: rtl/memory_burst_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : memory_burst_arbiter_if
//  Description : Bus bundle between the load/store request paths, the memory
//                command port and the burst arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface memory_burst_arbiter_if #(
    parameter int ADDR_WIDTH = 21
);
    logic                  init_done;
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_gnt;
    logic                  rd_done;
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  wr_gnt;
    logic                  wr_data_en;
    logic                  wr_done;
    logic                  cmd;
    logic                  cmd_en;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  rd_data_valid;
    logic                  error;

    // Arbiter side
    modport slave (
        input  init_done, rd_req, rd_addr, wr_req, wr_addr, rd_data_valid,
        output rd_gnt, rd_done, wr_gnt, wr_data_en, wr_done, cmd, cmd_en, addr, error
    );

    // Requester / memory side
    modport master (
        output init_done, rd_req, rd_addr, wr_req, wr_addr, rd_data_valid,
        input  rd_gnt, rd_done, wr_gnt, wr_data_en, wr_done, cmd, cmd_en, addr, error
    );
endinterface
`default_nettype wire

// File: rtl/memory_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : memory_burst_arbiter
//  Description : Round-robin arbiter between one read and one write burst
//                requester in front of a memory controller. Every output is a
//                flop: it shows the decision taken on the previous clock edge
//                (grant one cycle after the request is sampled in IDLE,
//                command strobe one cycle after the grant, write data enable
//                from the cycle after the command strobe, read done the cycle
//                after the last read word is sampled).
//  Revision    : 1.0  initial release
// ============================================================================
module memory_burst_arbiter #(
    parameter int BURST_LEN  = 32,
    parameter int ADDR_WIDTH = 21,
    parameter int GAP_CYCLES = 2,
    parameter int RD_TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    memory_burst_arbiter_if.slave bus
);

    localparam int C_BEAT_W = $clog2(BURST_LEN + 1);
    localparam int C_TMO_W  = $clog2(RD_TIMEOUT + 1);
    localparam int C_GAP_W  = $clog2(GAP_CYCLES + 1);

    localparam logic [C_BEAT_W-1:0] C_LAST_BEAT = C_BEAT_W'(BURST_LEN - 1);
    localparam logic [C_TMO_W-1:0]  C_TMO_LAST  = C_TMO_W'(RD_TIMEOUT - 1);
    localparam logic [C_GAP_W-1:0]  C_GAP_LAST  = C_GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_WAIT_INIT = 3'd0,
        S_IDLE      = 3'd1,
        S_CMD       = 3'd2,
        S_WR_DATA   = 3'd3,
        S_RD_WAIT   = 3'd4,
        S_GAP       = 3'd5
    } state_t;

    state_t                state_q,    state_d;
    logic [C_BEAT_W-1:0]   beat_q,     beat_d;      // write beats / read words
    logic [C_TMO_W-1:0]    tmo_q,      tmo_d;       // cycles since read command
    logic [C_GAP_W-1:0]    gap_q,      gap_d;
    logic                  dir_q,      dir_d;       // latched direction, 1 = write
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;  // latched request address
    logic                  last_wr_q,  last_wr_d;   // last grant went to write

    logic                  rd_gnt_q,     rd_gnt_d;
    logic                  wr_gnt_q,     wr_gnt_d;
    logic                  rd_done_q,    rd_done_d;
    logic                  wr_done_q,    wr_done_d;
    logic                  wr_data_en_q, wr_data_en_d;
    logic                  cmd_en_q,     cmd_en_d;
    logic                  cmd_q,        cmd_d;
    logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
    logic                  error_q,      error_d;

    // State and output registers; reset aborts any burst without a done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_WAIT_INIT;
            beat_q       <= '0;
            tmo_q        <= '0;
            gap_q        <= '0;
            dir_q        <= 1'b0;
            req_addr_q   <= '0;
            last_wr_q    <= 1'b1;
            rd_gnt_q     <= 1'b0;
            wr_gnt_q     <= 1'b0;
            rd_done_q    <= 1'b0;
            wr_done_q    <= 1'b0;
            wr_data_en_q <= 1'b0;
            cmd_en_q     <= 1'b0;
            cmd_q        <= 1'b0;
            addr_q       <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            tmo_q        <= tmo_d;
            gap_q        <= gap_d;
            dir_q        <= dir_d;
            req_addr_q   <= req_addr_d;
            last_wr_q    <= last_wr_d;
            rd_gnt_q     <= rd_gnt_d;
            wr_gnt_q     <= wr_gnt_d;
            rd_done_q    <= rd_done_d;
            wr_done_q    <= wr_done_d;
            wr_data_en_q <= wr_data_en_d;
            cmd_en_q     <= cmd_en_d;
            cmd_q        <= cmd_d;
            addr_q       <= addr_d;
            error_q      <= error_d;
        end
    end

    // Next state, arbitration and next values of the registered outputs
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        tmo_d        = tmo_q;
        gap_d        = gap_q;
        dir_d        = dir_q;
        req_addr_d   = req_addr_q;
        last_wr_d    = last_wr_q;
        rd_gnt_d     = 1'b0;
        wr_gnt_d     = 1'b0;
        rd_done_d    = 1'b0;
        wr_done_d    = 1'b0;
        wr_data_en_d = 1'b0;
        cmd_en_d     = 1'b0;
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        error_d      = error_q;

        unique case (state_q)
            S_WAIT_INIT: begin
                if (bus.init_done) begin
                    state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                // A tie goes to whichever side was not granted last
                if (bus.rd_req && (!bus.wr_req || last_wr_q)) begin
                    rd_gnt_d   = 1'b1;
                    dir_d      = 1'b0;
                    req_addr_d = bus.rd_addr;
                    last_wr_d  = 1'b0;
                    state_d    = S_CMD;
                end else if (bus.wr_req) begin
                    wr_gnt_d   = 1'b1;
                    dir_d      = 1'b1;
                    req_addr_d = bus.wr_addr;
                    last_wr_d  = 1'b1;
                    state_d    = S_CMD;
                end
            end

            S_CMD: begin
                cmd_en_d = 1'b1;
                cmd_d    = dir_q;
                addr_d   = req_addr_q;
                beat_d   = '0;
                tmo_d    = '0;
                state_d  = dir_q ? S_WR_DATA : S_RD_WAIT;
            end

            S_WR_DATA: begin
                wr_data_en_d = 1'b1;
                if (beat_q == C_LAST_BEAT) begin
                    wr_done_d = 1'b1;
                    gap_d     = '0;
                    state_d   = S_GAP;
                end else begin
                    beat_d = beat_q + C_BEAT_W'(1);
                end
            end

            S_RD_WAIT: begin
                // Completion by word count wins over a timeout in the same cycle
                if (bus.rd_data_valid && (beat_q == C_LAST_BEAT)) begin
                    rd_done_d = 1'b1;
                    gap_d     = '0;
                    state_d   = S_GAP;
                end else if (tmo_q == C_TMO_LAST) begin
                    rd_done_d = 1'b1;
                    error_d   = 1'b1;
                    gap_d     = '0;
                    state_d   = S_GAP;
                end else begin
                    if (bus.rd_data_valid) begin
                        beat_d = beat_q + C_BEAT_W'(1);
                    end
                    tmo_d = tmo_q + C_TMO_W'(1);
                end
            end

            S_GAP: begin
                if (gap_q == C_GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + C_GAP_W'(1);
                end
            end

            default: begin
                state_d = S_WAIT_INIT;
            end
        endcase
    end

    assign bus.rd_gnt     = rd_gnt_q;
    assign bus.wr_gnt     = wr_gnt_q;
    assign bus.rd_done    = rd_done_q;
    assign bus.wr_done    = wr_done_q;
    assign bus.wr_data_en = wr_data_en_q;
    assign bus.cmd_en     = cmd_en_q;
    assign bus.cmd        = cmd_q;
    assign bus.addr       = addr_q;
    assign bus.error      = error_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_burst_arbiter
//  Description : Self-checking bench for memory_burst_arbiter. A timeline
//                model predicts every output each cycle; directed scenarios
//                pin the model with literal latencies.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_memory_burst_arbiter;

    localparam int BL  = 32;
    localparam int AW  = 21;
    localparam int GAP = 2;
    localparam int RT  = 256;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    memory_burst_arbiter_if #(.ADDR_WIDTH(AW)) ifc ();

    memory_burst_arbiter #(
        .BURST_LEN  (BL),
        .ADDR_WIDTH (AW),
        .GAP_CYCLES (GAP),
        .RD_TIMEOUT (RT)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return ifc.rd_gnt;
            1:       return ifc.wr_gnt;
            2:       return ifc.cmd_en;
            3:       return ifc.wr_done;
            default: return ifc.rd_done;
        endcase
    endfunction

    // Bounded wait for an output; returns the cycle it was seen or -1
    task automatic wait_out(input int which, input int max_cyc, input string name, output int seen);
        seen = -1;
        for (int i = 0; i < max_cyc; i++) begin
            if (sel(which)) begin
                seen = cyc;
                break;
            end
            tick();
        end
        if (seen < 0) chk({name, "_wait_expired"}, 32'd0, 32'd1);
    endtask

    // ------------------------------------------------------------------
    // Timeline model: one burst at a time, outputs expressed as cycle
    // numbers derived from the grant cycle and the read-word arrivals.
    // ------------------------------------------------------------------
    bit            m_valid = 1'b0;
    bit            m_init, m_busy, m_wr, m_tmo, m_cmd, m_err, m_last_wr;
    int            m_avail, m_gnt_c, m_cmd_c, m_done_c, m_cnt;
    logic [AW-1:0] m_gaddr, m_addr;

    always @(negedge clk) begin
        int  k;
        bit  e_rdg, e_wrg, e_rdd, e_wrd, e_den, e_ce;
        k = cyc;
        if (m_valid) begin
            if (m_busy && k == m_cmd_c) begin
                m_addr = m_gaddr;
                m_cmd  = m_wr;
            end
            if (m_busy && m_tmo && k == m_done_c) m_err = 1'b1;
            e_rdg = m_busy && !m_wr && k == m_gnt_c;
            e_wrg = m_busy &&  m_wr && k == m_gnt_c;
            e_ce  = m_busy && k == m_cmd_c;
            e_den = m_busy &&  m_wr && k > m_cmd_c && k <= m_cmd_c + BL;
            e_wrd = m_busy &&  m_wr && k == m_done_c;
            e_rdd = m_busy && !m_wr && k == m_done_c;
            chk("rd_gnt",     32'(ifc.rd_gnt),     32'(e_rdg));
            chk("wr_gnt",     32'(ifc.wr_gnt),     32'(e_wrg));
            chk("cmd_en",     32'(ifc.cmd_en),     32'(e_ce));
            chk("cmd",        32'(ifc.cmd),        32'(m_cmd));
            chk("addr",       32'(ifc.addr),       32'(m_addr));
            chk("wr_data_en", 32'(ifc.wr_data_en), 32'(e_den));
            chk("wr_done",    32'(ifc.wr_done),    32'(e_wrd));
            chk("rd_done",    32'(ifc.rd_done),    32'(e_rdd));
            chk("error",      32'(ifc.error),      32'(m_err));
        end

        if (rst) begin
            m_valid   = 1'b1;
            m_init    = 1'b0;
            m_busy    = 1'b0;
            m_wr      = 1'b0;
            m_tmo     = 1'b0;
            m_cmd     = 1'b0;
            m_err     = 1'b0;
            m_last_wr = 1'b1;
            m_avail   = 32'h7fff_ffff;
            m_gnt_c   = -10;
            m_cmd_c   = -10;
            m_done_c  = -10;
            m_cnt     = 0;
            m_gaddr   = '0;
            m_addr    = '0;
        end else if (m_valid) begin
            if (m_busy && m_done_c >= 0 && k >= m_done_c) m_busy = 1'b0;
            if (!m_init) begin
                if (ifc.init_done) begin
                    m_init  = 1'b1;
                    m_avail = k + 1;
                end
            end else if (!m_busy && k >= m_avail && (ifc.rd_req || ifc.wr_req)) begin
                m_wr      = ifc.wr_req && (!ifc.rd_req || !m_last_wr);
                m_last_wr = m_wr;
                m_gaddr   = m_wr ? ifc.wr_addr : ifc.rd_addr;
                m_busy    = 1'b1;
                m_tmo     = 1'b0;
                m_cnt     = 0;
                m_gnt_c   = k + 1;
                m_cmd_c   = k + 2;
                if (m_wr) begin
                    m_done_c = k + 2 + BL;
                    m_avail  = m_done_c + GAP;
                end else begin
                    m_done_c = -1;
                end
            end else if (m_busy && !m_wr && m_done_c < 0 && k >= m_cmd_c) begin
                if (ifc.rd_data_valid) m_cnt++;
                if (m_cnt == BL) begin
                    m_done_c = k + 1;
                    m_avail  = m_done_c + GAP;
                end else if (k == m_cmd_c + RT - 1) begin
                    m_done_c = k + 1;
                    m_tmo    = 1'b1;
                    m_avail  = m_done_c + GAP;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int r, c, d, n, sent, ng, both, rate;
        logic [3:0] seq;

        rst               = 1'b1;
        ifc.init_done     = 1'b0;
        ifc.rd_req        = 1'b0;
        ifc.wr_req        = 1'b0;
        ifc.rd_addr       = '0;
        ifc.wr_addr       = '0;
        ifc.rd_data_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Requests before init_done are ignored
        ifc.rd_req = 1'b1; ifc.rd_addr = 21'h00AAA;
        ifc.wr_req = 1'b1; ifc.wr_addr = 21'h00BBB;
        n = 0;
        repeat (20) begin
            tick();
            if (ifc.cmd_en || ifc.rd_gnt || ifc.wr_gnt) n++;
        end
        chk("no_activity_before_init", 32'(n), 32'd0);
        ifc.rd_req = 1'b0;
        ifc.wr_req = 1'b0;
        ifc.init_done = 1'b1;
        tick();
        tick();

        // Single write burst
        ifc.wr_req = 1'b1; ifc.wr_addr = 21'h00100; r = cyc;
        wait_out(1, 10, "wr_gnt", c);
        ifc.wr_req = 1'b0;
        chk("wr_gnt_latency", 32'(c - r), 32'd1);
        wait_out(2, 10, "wr_cmd_en", c);
        chk("wr_cmd_latency", 32'(c - r), 32'd2);
        chk("wr_cmd_dir", 32'(ifc.cmd), 32'd1);
        chk("wr_cmd_addr", 32'(ifc.addr), 32'h00100);
        n = 0; d = -1;
        repeat (40) begin
            tick();
            if (ifc.wr_data_en) n++;
            if (ifc.wr_done) d = cyc;
        end
        chk("wr_data_en_cycles", 32'(n), 32'd32);
        chk("wr_done_latency", 32'(d - r), 32'd34);

        // Single read burst, words arriving with gaps
        ifc.rd_req = 1'b1; ifc.rd_addr = 21'h1F000;
        wait_out(0, 10, "rd_gnt", c);
        ifc.rd_req = 1'b0;
        wait_out(2, 10, "rd_cmd_en", c);
        chk("rd_cmd_dir", 32'(ifc.cmd), 32'd0);
        chk("rd_cmd_addr", 32'(ifc.addr), 32'h1F000);
        sent = 0;
        for (int j = 0; j < 200 && sent < BL; j++) begin
            ifc.rd_data_valid = (j % 3 != 2);
            if (ifc.rd_data_valid) sent++;
            tick();
        end
        ifc.rd_data_valid = 1'b0;
        chk("rd_done_after_last_word", 32'(ifc.rd_done), 32'd1);
        chk("rd_error_clear", 32'(ifc.error), 32'd0);
        repeat (5) tick();

        // Contention after reset: first tie goes to read, then alternate
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ifc.rd_req = 1'b1; ifc.wr_req = 1'b1; ifc.rd_data_valid = 1'b1;
        seq = '0; ng = 0; both = 0;
        for (int j = 0; j < 600 && ng < 4; j++) begin
            tick();
            if (ifc.rd_gnt && ifc.wr_gnt) both++;
            if (ifc.rd_gnt) begin seq = {seq[2:0], 1'b0}; ng++; end
            if (ifc.wr_gnt) begin seq = {seq[2:0], 1'b1}; ng++; end
        end
        ifc.rd_req = 1'b0; ifc.wr_req = 1'b0;
        chk("grant_order_RWRW", 32'(seq), 32'b0101);
        chk("no_double_grant", 32'(both), 32'd0);
        repeat (60) tick();
        ifc.rd_data_valid = 1'b0;

        // Read timeout after 10 words, then a normal write
        ifc.rd_req = 1'b1; ifc.rd_addr = 21'h00777;
        wait_out(0, 10, "tmo_rd_gnt", c);
        ifc.rd_req = 1'b0;
        wait_out(2, 10, "tmo_cmd_en", c);
        for (int j = 0; j < 10; j++) begin
            ifc.rd_data_valid = 1'b1;
            tick();
        end
        ifc.rd_data_valid = 1'b0;
        wait_out(4, 300, "tmo_rd_done", d);
        chk("timeout_latency", 32'(d - c), 32'd256);
        chk("timeout_error", 32'(ifc.error), 32'd1);
        ifc.wr_req = 1'b1; ifc.wr_addr = 21'h00555;
        wait_out(1, 10, "post_tmo_wr_gnt", c);
        ifc.wr_req = 1'b0;
        wait_out(3, 60, "post_tmo_wr_done", d);
        chk("error_sticky", 32'(ifc.error), 32'd1);
        repeat (5) tick();

        // Reset in the fifth write data cycle
        ifc.wr_req = 1'b1; ifc.wr_addr = 21'h12345;
        wait_out(1, 10, "rst_wr_gnt", c);
        ifc.wr_req = 1'b0;
        wait_out(2, 10, "rst_cmd_en", c);
        while (cyc < c + 5) tick();
        rst = 1'b1;
        ifc.init_done = 1'b0;
        tick();
        rst = 1'b0;
        chk("outputs_after_reset",
            {8'd0, ifc.rd_gnt, ifc.rd_done, ifc.wr_gnt, ifc.wr_data_en, ifc.wr_done,
             ifc.cmd, ifc.cmd_en, ifc.error, 3'd0, ifc.addr}, 32'd0);
        n = 0;
        repeat (40) begin
            tick();
            if (ifc.wr_done || ifc.wr_data_en) n++;
        end
        chk("no_write_after_reset", 32'(n), 32'd0);
        ifc.init_done = 1'b1;

        // Randomized traffic with occasional drops, resets and slow memory
        rate = 80;
        for (int i = 0; i < 3600; i++) begin
            tick();
            if (i % 600 == 0) begin
                case ($urandom_range(0, 2))
                    0:       rate = 85;
                    1:       rate = 40;
                    default: rate = 4;
                endcase
            end
            rst = ($urandom_range(0, 999) == 0);
            if (ifc.wr_req) begin
                if (ifc.wr_gnt || $urandom_range(0, 99) < 2) ifc.wr_req = 1'b0;
            end else if ($urandom_range(0, 99) < 10) begin
                ifc.wr_req  = 1'b1;
                ifc.wr_addr = AW'($urandom);
            end
            if (ifc.rd_req) begin
                if (ifc.rd_gnt || $urandom_range(0, 99) < 2) ifc.rd_req = 1'b0;
            end else if ($urandom_range(0, 99) < 10) begin
                ifc.rd_req  = 1'b1;
                ifc.rd_addr = AW'($urandom);
            end
            ifc.rd_data_valid = ($urandom_range(0, 99) < rate);
        end
        rst = 1'b0;
        ifc.rd_req = 1'b0;
        ifc.wr_req = 1'b0;
        ifc.rd_data_valid = 1'b0;
        repeat (5) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
